// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: drives one active-low column at a time, samples synchronised rows,
// debounces whole-scan results and reports accepted presses as a code plus a one-cycle strobe.
module keypad_scanner #(
  parameter int unsigned SettleCyc     = 16,
  parameter int unsigned DebounceScans = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] kp_row_i,
  output logic [3:0] kp_col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_down_o,
  output logic       multi_key_o
);

  localparam int unsigned DwellW = (SettleCyc > 2) ? $clog2(SettleCyc) : 2;
  localparam int unsigned CntW   = $clog2(DebounceScans + 1);

  localparam logic [DwellW-1:0] DwellLast = DwellW'(SettleCyc - 1);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);
  localparam logic [CntW-1:0]   CntTarget = CntW'(DebounceScans);

  typedef enum logic [1:0] {
    StIdle,
    StDebPress,
    StPressed,
    StDebRelease
  } state_e;

  // Row synchroniser
  logic [3:0] row_meta_q, row_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= kp_row_i;
      row_sync_q <= row_meta_q;
    end
  end

  // Column scan
  logic              active_q, active_d;
  logic [1:0]        col_q, col_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [15:0]       map_q, map_d;
  logic              scan_done;

  always_comb begin
    active_d  = 1'b1;
    col_d     = col_q;
    dwell_d   = dwell_q;
    map_d     = map_q;
    scan_done = 1'b0;
    if (!active_q) begin
      col_d   = 2'd0;
      dwell_d = '0;
    end else if (dwell_q == DwellLast) begin
      dwell_d   = '0;
      col_d     = col_q + 2'd1;
      scan_done = (col_q == 2'd3);
      for (int r = 0; r < 4; r++) begin
        map_d[4 * r + int'(col_q)] = ~row_sync_q[r];
      end
    end else begin
      dwell_d = dwell_q + DwellW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      col_q    <= 2'd0;
      dwell_q  <= '0;
      map_q    <= '0;
    end else begin
      active_q <= active_d;
      col_q    <= col_d;
      dwell_q  <= dwell_d;
      map_q    <= map_d;
    end
  end

  // Columns stay released until the first clock after reset release
  assign kp_col_o = active_q ? ~(4'b0001 << col_q) : 4'hF;

  // Classify the completed map: none, exactly one key (with its code), or several
  logic       res_found, res_multi;
  logic [3:0] res_code;

  always_comb begin
    res_found = 1'b0;
    res_multi = 1'b0;
    res_code  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (map_d[i]) begin
        if (res_found) begin
          res_multi = 1'b1;
        end else begin
          res_found = 1'b1;
          res_code  = 4'(i);
        end
      end
    end
  end

  logic res_key, res_none;
  assign res_key  = res_found && !res_multi;
  assign res_none = !res_found;

  // Debounce FSM, stepped once per completed scan
  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            down_q, down_d;
  logic            multi_q, multi_d;

  assign cnt_inc = cnt_q + CntOne;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;
    multi_d = multi_q;
    if (scan_done) begin
      multi_d = res_multi;
      unique case (state_q)
        StIdle, StDebPress: begin
          if (res_key && state_q == StDebPress && res_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntTarget) begin
              state_d = StPressed;
              code_d  = cand_q;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end
          end else if (res_key) begin
            // New candidate; a single-scan debounce accepts it immediately
            cand_d = res_code;
            cnt_d  = CntOne;
            if (CntOne == CntTarget) begin
              state_d = StPressed;
              code_d  = res_code;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end else begin
              state_d = StDebPress;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StPressed: begin
          if (res_none) begin
            cnt_d = CntOne;
            if (CntOne == CntTarget) begin
              state_d = StIdle;
              down_d  = 1'b0;
            end else begin
              state_d = StDebRelease;
            end
          end
        end
        StDebRelease: begin
          if (res_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntTarget) begin
              state_d = StIdle;
              down_d  = 1'b0;
            end
          end else begin
            state_d = StPressed;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
      multi_q <= multi_d;
    end
  end

  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_down_o  = down_q;
  assign multi_key_o = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural key matrix plus a run-length model of the
// debounce rules, checked scan by scan with directed and random key patterns.
module tb_keypad_scanner;

  localparam int Settle = 4;
  localparam int Deb    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  kp_row, kp_col, key_code;
  logic        key_valid, key_down, multi_key;
  logic [15:0] pressed = 16'h0;

  int total = 0;
  int bad   = 0;

  // Model state: history of scan results (-1 none, -2 multi, else key code)
  int         hist[$];
  logic       m_down, m_valid, m_multi;
  logic [3:0] m_code;

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp_col[c] && pressed[r * 4 + c]) kp_row[r] = 1'b0;
  end

  keypad_scanner #(
    .SettleCyc    (Settle),
    .DebounceScans(Deb)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .kp_row_i   (kp_row),
    .kp_col_o   (kp_col),
    .key_code_o (key_code),
    .key_valid_o(key_valid),
    .key_down_o (key_down),
    .multi_key_o(multi_key)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_down  = 1'b0;
    m_valid = 1'b0;
    m_multi = 1'b0;
    m_code  = 4'd0;
  endtask

  function automatic bit last_runs(input int v);
    if (hist.size() < Deb) return 1'b0;
    for (int i = 0; i < Deb; i++)
      if (hist[hist.size() - 1 - i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_scan(input logic [15:0] p);
    int n;
    int res;
    n = $countones(p);
    res = -1;
    if (n > 1) res = -2;
    else if (n == 1) for (int i = 0; i < 16; i++) if (p[i]) res = i;
    hist.push_back(res);
    m_multi = (res == -2);
    m_valid = 1'b0;
    if (!m_down && res >= 0 && last_runs(res)) begin
      m_valid = 1'b1;
      m_down  = 1'b1;
      m_code  = 4'(res);
    end else if (m_down && last_runs(-1)) begin
      m_down = 1'b0;
    end
  endtask

  // One full scan from its first column-0 cycle; keys change only at scan start
  task automatic scan(input logic [15:0] p);
    logic [3:0] ec;
    pressed = p;
    for (int j = 0; j < 4 * Settle; j++) begin
      ec = 4'b0001 << (j / Settle);
      chk("kp_col", kp_col, ~ec);
      if (j > 0) chk("valid_mid", {3'b0, key_valid}, 4'd0);
      @(posedge clk);
      #1;
    end
    model_scan(p);
    chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
    chk("key_down", {3'b0, key_down}, {3'b0, m_down});
    chk("multi_key", {3'b0, multi_key}, {3'b0, m_multi});
    chk("key_code", key_code, m_code);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"}, kp_col, 4'hF);
    chk({tag, "_valid"}, {3'b0, key_valid}, 4'd0);
    chk({tag, "_down"}, {3'b0, key_down}, 4'd0);
    chk({tag, "_multi"}, {3'b0, multi_key}, 4'd0);
    chk({tag, "_code"}, key_code, 4'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    logic [15:0] p;
    int kind, hold;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    release_reset();

    repeat (2) scan(16'h0);

    // Key 9 (row 2, col 1): accepted on the third scan, then held
    repeat (5) scan(16'h0200);
    // One-scan dropout does not release or re-strobe
    scan(16'h0);
    repeat (2) scan(16'h0200);
    // Extra key while held: multi flag, no strobe
    repeat (2) scan(16'h0201);
    repeat (3) scan(16'h0);

    // Chattering key never accepted
    repeat (10) begin
      scan(16'h0020);
      scan(16'h0);
    end

    // Two keys from idle
    repeat (2) scan(16'h0021);
    scan(16'h0);

    // Random patterns held for random run lengths
    repeat (40) begin
      kind = $urandom_range(0, 3);
      p = 16'h0;
      if (kind == 1 || kind == 2) p[$urandom_range(0, 15)] = 1'b1;
      else if (kind == 3) begin
        p[$urandom_range(0, 15)] = 1'b1;
        p[$urandom_range(0, 15)] = 1'b1;
      end
      hold = $urandom_range(1, 4);
      repeat (hold) scan(p);
    end

    // Reset in the middle of a pending press
    repeat (3) scan(16'h0);
    repeat (2) scan(16'h0008);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst_hold");
    release_reset();
    repeat (3) scan(16'h0008);
    repeat (3) scan(16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
